camera_pwr_seq_master: RTL and testbench



---
 rtl/camera_pwr_pkg.sv | 29 ++
 rtl/avm_single_xfer.sv | 54 +++++
 rtl/camera_pwr_seq_master.sv | 177 +++++++++++++++++
 tb/tb_camera_pwr_seq_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pwr_pkg.sv
// rtl/camera_pwr_pkg.sv - shared state encoding and PIO constants for the camera power sequencer
package camera_pwr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_PD0,
        ST_W_RST0,
        ST_W_PD1,
        ST_WAIT1,
        ST_R_PD,
        ST_W_RST1,
        ST_WAIT2,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [31:0] PIO_DATA_OFS = 32'h0000_0000;

    // Both camera pins are active-low: 0 holds the sensor off / in reset.
    localparam logic PWDN_ASSERT  = 1'b0;
    localparam logic PWDN_RELEASE = 1'b1;
    localparam logic RST_ASSERT   = 1'b0;
    localparam logic RST_RELEASE  = 1'b1;

    function automatic logic [31:0] pio_word(input logic level);
        return {31'b0, level};
    endfunction

endpackage

// File: rtl/avm_single_xfer.sv
// rtl/avm_single_xfer.sv - single Avalon-MM read or write with waitrequest hold and stall timeout
module avm_single_xfer #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        go_read,
    input  logic [31:0] go_addr,
    input  logic [31:0] go_wdata,
    output logic        xfer_done,
    output logic        xfer_timeout,
    output logic [31:0] rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    logic              active;
    logic [WCNT_W-1:0] wait_cnt;

    assign active = avm_read | avm_write;
    assign xfer_done = active & ~avm_waitrequest;
    // wait_cnt holds the stalls already seen, so this fires on the TIMEOUT-th stalled cycle.
    assign xfer_timeout = active & avm_waitrequest & (wait_cnt == WCNT_W'(TIMEOUT - 1));
    assign rdata = avm_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            wait_cnt      <= '0;
        end else if (go) begin
            avm_address   <= go_addr;
            avm_writedata <= go_wdata;
            avm_read      <= go_read;
            avm_write     <= ~go_read;
            wait_cnt      <= '0;
        end else if (xfer_done || xfer_timeout) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
        end else if (active) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

endmodule

// File: rtl/camera_pwr_seq_master.sv
// rtl/camera_pwr_seq_master.sv - Avalon-MM master driving the camera pwdn_n/reset_n power-up sequence
module camera_pwr_seq_master #(
    parameter logic [31:0] PWDN_BASE = 32'h0000_0000,
    parameter logic [31:0] RST_BASE  = 32'h0000_0010,
    parameter int          DLY_PWDN  = 1000,
    parameter int          DLY_RESET = 2000,
    parameter int          CNT_W     = 24,
    parameter int          TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    import camera_pwr_pkg::*;

    localparam logic [31:0] PWDN_ADDR = PWDN_BASE + PIO_DATA_OFS;
    localparam logic [31:0] RST_ADDR  = RST_BASE + PIO_DATA_OFS;

    state_t             state;
    logic [CNT_W-1:0]   dly_cnt;
    logic               armed;
    logic               start_ok;
    logic               go;
    logic               go_read;
    logic [31:0]        go_addr;
    logic [31:0]        go_wdata;
    logic               xfer_done;
    logic               xfer_timeout;
    logic [31:0]        rdata;
    logic               unused_rdata_hi;

    assign unused_rdata_hi = ^rdata[31:1];

    // armed blocks a start sampled on the first edge after reset release.
    assign start_ok = start & armed &
                      ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));

    // The next request is launched on the same edge that completes the current one.
    always_comb begin
        go       = 1'b0;
        go_read  = 1'b0;
        go_addr  = PWDN_ADDR;
        go_wdata = pio_word(PWDN_ASSERT);
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                go = start_ok;
            end
            ST_W_PD0: begin
                if (xfer_done) begin
                    go       = 1'b1;
                    go_addr  = RST_ADDR;
                    go_wdata = pio_word(RST_ASSERT);
                end
            end
            ST_W_RST0: begin
                if (xfer_done) begin
                    go       = 1'b1;
                    go_wdata = pio_word(PWDN_RELEASE);
                end
            end
            ST_WAIT1: begin
                if (dly_cnt == '0) begin
                    go       = 1'b1;
                    go_read  = 1'b1;
                    go_wdata = '0;
                end
            end
            ST_R_PD: begin
                if (xfer_done && (rdata[0] == PWDN_RELEASE)) begin
                    go       = 1'b1;
                    go_addr  = RST_ADDR;
                    go_wdata = pio_word(RST_RELEASE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
            armed   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (xfer_timeout) begin
                state <= ST_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (start_ok) begin
                            state <= ST_W_PD0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            error <= 1'b0;
                        end
                    end
                    ST_W_PD0:  if (xfer_done) state <= ST_W_RST0;
                    ST_W_RST0: if (xfer_done) state <= ST_W_PD1;
                    ST_W_PD1: begin
                        if (xfer_done) begin
                            state   <= ST_WAIT1;
                            dly_cnt <= CNT_W'(DLY_PWDN - 1);
                        end
                    end
                    ST_WAIT1: begin
                        if (dly_cnt == '0) state <= ST_R_PD;
                        else               dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                    ST_R_PD: begin
                        if (xfer_done) begin
                            if (rdata[0] == PWDN_RELEASE) begin
                                state <= ST_W_RST1;
                            end else begin
                                state <= ST_ERR;
                                busy  <= 1'b0;
                                error <= 1'b1;
                            end
                        end
                    end
                    ST_W_RST1: begin
                        if (xfer_done) begin
                            state   <= ST_WAIT2;
                            dly_cnt <= CNT_W'(DLY_RESET - 1);
                        end
                    end
                    ST_WAIT2: begin
                        if (dly_cnt == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt - CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    avm_single_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk             (clk),
        .reset_n         (reset_n),
        .go              (go),
        .go_read         (go_read),
        .go_addr         (go_addr),
        .go_wdata        (go_wdata),
        .xfer_done       (xfer_done),
        .xfer_timeout    (xfer_timeout),
        .rdata           (rdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

endmodule

// File: tb/tb_camera_pwr_seq_master.sv
// tb/tb_camera_pwr_seq_master.sv - self-checking bench for camera_pwr_seq_master
module tb_camera_pwr_seq_master;

    localparam int          DLY_PWDN  = 4;
    localparam int          DLY_RESET = 6;
    localparam int          TIMEOUT   = 8;
    localparam logic [31:0] PWDN_BASE = 32'h0000_0000;
    localparam logic [31:0] RST_BASE  = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [31:0] avm_address, avm_writedata;
    logic        avm_read, avm_write;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    camera_pwr_seq_master #(
        .PWDN_BASE (PWDN_BASE),
        .RST_BASE  (RST_BASE),
        .DLY_PWDN  (DLY_PWDN),
        .DLY_RESET (DLY_RESET),
        .CNT_W     (24),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // Slave-side model: completed transfers, planned stalls, stability tracking.
    logic [64:0] txn_q[$];
    logic [64:0] exp_q[$];
    int          stall_q[$];
    logic [31:0] rd_value;
    bit          in_xfer;
    int          stall_left, stall_cnt, unstable, both_hi;
    logic [64:0] cur_req;
    int          st[5];

    function automatic logic [64:0] req_word(input logic rd, input logic [31:0] a, input logic [31:0] d);
        return {rd, a, (rd ? 32'h0 : d)};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic service();
        logic [64:0] req;
        if (avm_read && avm_write) both_hi++;
        req = req_word(avm_read, avm_address, avm_writedata);
        if (avm_read || avm_write) begin
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                cur_req    = req;
                stall_cnt  = 0;
                stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
            end else if (req !== cur_req) begin
                unstable++;
            end
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                stall_left--;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = rd_value;
                txn_q.push_back(req);
                in_xfer = 1'b0;
            end
        end else begin
            in_xfer         = 1'b0;
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata    = $urandom;
        end
    endtask

    task automatic tick(input logic st_in);
        @(negedge clk);
        start = st_in;
        service();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string tag, input int s[5], input logic [31:0] rdv, input int extra_at);
        logic [64:0] plan[5];
        int          lat_exp, n, nexp;
        bit          to_exp, ok_exp, busy_bad;
        plan[0] = req_word(1'b0, PWDN_BASE, 32'd0);
        plan[1] = req_word(1'b0, RST_BASE, 32'd0);
        plan[2] = req_word(1'b0, PWDN_BASE, 32'd1);
        plan[3] = req_word(1'b1, PWDN_BASE, 32'd0);
        plan[4] = req_word(1'b0, RST_BASE, 32'd1);
        txn_q.delete(); exp_q.delete(); stall_q.delete();
        rd_value = rdv; in_xfer = 1'b0; unstable = 0; both_hi = 0;
        lat_exp = 5 + DLY_PWDN + DLY_RESET;
        to_exp  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4 && !rdv[0]) break;
            stall_q.push_back(s[i]);
            if (s[i] >= TIMEOUT) begin
                to_exp = 1'b1;
                break;
            end
            exp_q.push_back(plan[i]);
            lat_exp += s[i];
        end
        ok_exp = !to_exp && rdv[0];

        tick(1'b1);
        chk({tag, " busy_at_start"}, busy, 1'b1);
        chk({tag, " done_cleared"}, done, 1'b0);
        chk({tag, " error_cleared"}, error, 1'b0);
        n = 0;
        busy_bad = 1'b0;
        while (n < 300) begin
            tick(n + 1 == extra_at);
            n++;
            if (done || error) break;
            if (!busy) busy_bad = 1'b1;
        end
        chk({tag, " done"}, done, ok_exp);
        chk({tag, " error"}, error, !ok_exp);
        chk({tag, " busy_end"}, busy, 1'b0);
        chk({tag, " busy_span"}, busy_bad, 1'b0);
        if (ok_exp) chk({tag, " latency"}, n, lat_exp);
        chk({tag, " txn_count"}, txn_q.size(), exp_q.size());
        nexp = (txn_q.size() < exp_q.size()) ? txn_q.size() : exp_q.size();
        for (int i = 0; i < nexp; i++) chk({tag, " txn"}, txn_q[i], exp_q[i]);
        chk({tag, " stall_stable"}, unstable, 0);
        chk({tag, " rd_wr_excl"}, both_hi, 0);
        if (to_exp) begin
            chk({tag, " timeout_stalls"}, stall_cnt, TIMEOUT);
            chk({tag, " req_dropped"}, {avm_read, avm_write}, 2'b00);
        end
    endtask

    initial begin
        bit        act;
        int        r;
        rd_value = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst read", avm_read, 1'b0);
        chk("rst write", avm_write, 1'b0);
        chk("rst address", avm_address, 32'h0);
        chk("rst writedata", avm_writedata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick(1'b0);

        st = '{0, 0, 0, 0, 0};
        run_seq("nominal", st, {$urandom, 1'b1} & 32'hFFFF_FFFF, 0);
        st = '{0, 0, 3, 0, 0};
        run_seq("stall3_pd1", st, 32'h1, 0);
        st = '{0, TIMEOUT + 50, 0, 0, 0};
        run_seq("timeout_rst0", st, 32'h1, 0);
        st = '{0, 0, 0, 0, 0};
        run_seq("rerun_ign_wait1", st, 32'h8000_0001, 6);
        run_seq("readback_bad", st, 32'hFFFF_FFFE, 0);
        st = '{0, 0, 0, TIMEOUT - 1, 0};
        run_seq("stall_tmo_minus1", st, 32'h1, 0);
        st = '{0, 0, 0, 0, TIMEOUT};
        run_seq("stall_tmo_exact", st, 32'h1, 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 5; i++) begin
                r = int'($urandom_range(0, 15));
                st[i] = (r < 12) ? (r % 4) : ((r < 14) ? TIMEOUT - 1 : TIMEOUT + r - 14);
            end
            run_seq("random", st, {$urandom, ($urandom_range(0, 3) != 0)} & 32'hFFFF_FFFF,
                    int'($urandom_range(0, 30)));
        end

        // Abort in WAIT2 with an asynchronous reset.
        stall_q.delete(); in_xfer = 1'b0; rd_value = 32'h1;
        tick(1'b1);
        repeat (11) tick(1'b0);
        chk("wait2 busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async busy", busy, 1'b0);
        chk("async done_err", {done, error}, 2'b00);
        chk("async req", {avm_read, avm_write}, 2'b00);
        chk("async addr_data", {avm_address, avm_writedata}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        act = 1'b0;
        repeat (5) begin
            tick(1'b0);
            act |= avm_read | avm_write | busy | done | error;
        end
        chk("post_reset idle", act, 1'b0);

        st = '{0, 0, 0, 0, 0};
        run_seq("after_reset", st, 32'h1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
